spectrum_shifter: RTL and testbench

Pitch-shift stage for the spectral path: after the fundamental and target frequencies are known, it resamples the stored FFT spectrum along the frequency axis by a fixed ratio. It reads bins 0..255 from the spectrum RAM and linearly interpolates between adjacent bins. It writes the Hermitian-symmetric 512-bin result into the output RAM that feeds the IFFT. It is started by the main controller once the shift ratio is computed, and it reports completion with a one-cycle `done` pulse.

---
 rtl/spectrum_shifter_pkg.sv | 37 +++
 rtl/spectrum_shifter_if.sv | 25 ++
 rtl/bin_interp.sv | 32 +++
 rtl/spectrum_shifter.sv | 150 +++++++++++++++
 tb/tb_spectrum_shifter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/spectrum_shifter_pkg.sv
// Shared constants, bin word layout and state encoding for the spectral pitch-shift stage.
package spectrum_shifter_pkg;

  localparam int N_BINS  = 512;
  localparam int HALF    = N_BINS / 2;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 36;
  localparam int PART_W  = DATA_W / 2;
  localparam int RATIO_W = 16;
  localparam int FRAC_W  = 14;
  localparam int ACC_W   = 25;
  localparam int IDX_W   = ACC_W - FRAC_W;
  localparam int K_W     = 8;
  localparam int ST_W    = 10;

  localparam logic signed [PART_W-1:0] PART_MIN = {1'b1, {(PART_W-1){1'b0}}};
  localparam logic signed [PART_W-1:0] PART_MAX = {1'b0, {(PART_W-1){1'b1}}};

  typedef struct packed {
    logic signed [PART_W-1:0] re;
    logic signed [PART_W-1:0] im;
  } bin_t;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 10'b00_0000_0001,
    ST_CHECK  = 10'b00_0000_0010,
    ST_RD_LO  = 10'b00_0000_0100,
    ST_RD_HI  = 10'b00_0000_1000,
    ST_CAP_HI = 10'b00_0001_0000,
    ST_WRITE  = 10'b00_0010_0000,
    ST_ZERO   = 10'b00_0100_0000,
    ST_MIRROR = 10'b00_1000_0000,
    ST_NYQ    = 10'b01_0000_0000,
    ST_FIN    = 10'b10_0000_0000
  } state_e;

endpackage

// File: rtl/spectrum_shifter_if.sv
// Control, spectrum-RAM read and output-RAM write signals of the shifter.
interface spectrum_shifter_if;
  import spectrum_shifter_pkg::*;

  logic               start;
  logic [RATIO_W-1:0] inv_ratio;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  src_addr;
  logic [DATA_W-1:0]  src_data;
  logic [ADDR_W-1:0]  dst_addr;
  logic [DATA_W-1:0]  dst_data;
  logic               dst_we;

  modport master (
    output start, inv_ratio, src_data,
    input  busy, done, src_addr, dst_addr, dst_data, dst_we
  );

  modport slave (
    input  start, inv_ratio, src_data,
    output busy, done, src_addr, dst_addr, dst_data, dst_we
  );

endinterface

// File: rtl/bin_interp.sv
// Linear interpolation of one signed 18-bit part: lo + floor((hi - lo) * frac / 2^14).
module bin_interp
  import spectrum_shifter_pkg::*;
(
  input  logic signed [PART_W-1:0] lo_i,
  input  logic signed [PART_W-1:0] hi_i,
  input  logic        [FRAC_W-1:0] frac_i,
  output logic signed [PART_W-1:0] res_o
);

  localparam int PROD_W = PART_W + FRAC_W + 2;

  logic signed [PART_W:0]   diff;
  logic signed [PROD_W-1:0] diff_ext;
  logic signed [PROD_W-1:0] frac_ext;
  logic signed [PROD_W-1:0] prod;
  logic        [PART_W:0]   step;
  logic        [PART_W:0]   sum;
  logic                     unused_bits;

  assign diff     = {hi_i[PART_W-1], hi_i} - {lo_i[PART_W-1], lo_i};
  assign diff_ext = {{(PROD_W-PART_W-1){diff[PART_W]}}, diff};
  assign frac_ext = {{(PROD_W-FRAC_W){1'b0}}, frac_i};
  assign prod     = diff_ext * frac_ext;
  // Dropping the low FRAC_W bits of a two's-complement product is the floor shift.
  assign step     = prod[PART_W+FRAC_W:FRAC_W];
  assign sum      = {lo_i[PART_W-1], lo_i} + step;
  assign res_o    = sum[PART_W-1:0];

  assign unused_bits = ^{prod[PROD_W-1], prod[FRAC_W-1:0], sum[PART_W]};

endmodule

// File: rtl/spectrum_shifter.sv
// Resamples spectrum bins 0..255 by inv_ratio and writes the Hermitian 512-bin result.
module spectrum_shifter
  import spectrum_shifter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  spectrum_shifter_if.slave  bus
);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [RATIO_W-1:0]  ratio_q, ratio_d;
  logic [K_W-1:0]      k_q, k_d;
  bin_t                lo_q, lo_d, hi_q, hi_d;
  logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic [ADDR_W-1:0]   dst_addr_q, dst_addr_d;
  bin_t                dst_data_q, dst_data_d;
  logic                dst_we_q, dst_we_d;

  logic [IDX_W-1:0]    idx;
  logic [FRAC_W-1:0]   frac;
  bin_t                src_bin, interp_bin;
  logic                last_bin;

  function automatic logic signed [PART_W-1:0] neg_sat(input logic signed [PART_W-1:0] v);
    return (v == PART_MIN) ? PART_MAX : -v;
  endfunction

  assign idx      = acc_q[ACC_W-1:FRAC_W];
  assign frac     = acc_q[FRAC_W-1:0];
  assign src_bin  = bus.src_data;
  assign last_bin = (k_q == K_W'(HALF - 1));

  bin_interp u_interp_re (.lo_i(lo_q.re), .hi_i(hi_q.re), .frac_i(frac), .res_o(interp_bin.re));
  bin_interp u_interp_im (.lo_i(lo_q.im), .hi_i(hi_q.im), .frac_i(frac), .res_o(interp_bin.im));

  // NOTE: every target gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ratio_d    = ratio_q;
    k_d        = k_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    dst_we_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ratio_d = bus.inv_ratio;
          acc_d   = '0;
          k_d     = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (idx >= IDX_W'(HALF - 1)) begin
          state_d = ST_ZERO;
        end else begin
          src_addr_d = ADDR_W'(idx);
          state_d    = ST_RD_LO;
        end
      end
      ST_RD_LO: begin
        src_addr_d = ADDR_W'(idx + IDX_W'(1));
        state_d    = ST_RD_HI;
      end
      ST_RD_HI: begin
        lo_d    = src_bin;
        state_d = ST_CAP_HI;
      end
      ST_CAP_HI: begin
        hi_d    = src_bin;
        state_d = ST_WRITE;
      end
      ST_WRITE, ST_ZERO: begin
        dst_we_d   = 1'b1;
        dst_addr_d = ADDR_W'(k_q);
        dst_data_d = (state_q == ST_WRITE) ? interp_bin : '0;
        if (k_q == '0) begin
          k_d     = k_q + K_W'(1);
          acc_d   = acc_q + ACC_W'(ratio_q);
          state_d = ST_CHECK;
        end else begin
          state_d = ST_MIRROR;
        end
      end
      ST_MIRROR: begin
        // dst_data_q still holds bin k from the preceding WRITE/ZERO cycle.
        dst_we_d      = 1'b1;
        dst_addr_d    = ADDR_W'(N_BINS - int'(k_q));
        dst_data_d.re = dst_data_q.re;
        dst_data_d.im = neg_sat(dst_data_q.im);
        if (last_bin) begin
          state_d = ST_NYQ;
        end else begin
          k_d     = k_q + K_W'(1);
          acc_d   = acc_q + ACC_W'(ratio_q);
          state_d = ST_CHECK;
        end
      end
      ST_NYQ: begin
        dst_we_d   = 1'b1;
        dst_addr_d = ADDR_W'(HALF);
        dst_data_d = '0;
        state_d    = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      ratio_q    <= '0;
      k_q        <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      dst_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ratio_q    <= ratio_d;
      k_q        <= k_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      dst_we_q   <= dst_we_d;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign bus.done     = (state_q == ST_FIN);
  assign bus.src_addr = src_addr_q;
  assign bus.dst_addr = dst_addr_q;
  assign bus.dst_data = dst_data_q;
  assign bus.dst_we   = dst_we_q;

endmodule

// File: tb/tb_spectrum_shifter.sv
// Drives spectrum_shifter with ramp/random spectra and compares the output RAM to a resampling model.
module tb_spectrum_shifter;
  import spectrum_shifter_pkg::*;

  logic clk = 1'b0;
  logic reset;

  spectrum_shifter_if sif();
  spectrum_shifter dut (.clk(clk), .reset(reset), .bus(sif));

  always #5 clk = ~clk;

  logic [DATA_W-1:0] src_mem [0:N_BINS-1];
  logic [DATA_W-1:0] dst_mem [0:N_BINS-1];
  int seen [0:N_BINS-1];
  int wr_count, done_count, busy_cycles;
  int checks = 0;
  int errors = 0;

  // Spectrum RAM with one-cycle synchronous read.
  always @(posedge clk) sif.src_data <= src_mem[sif.src_addr];

  // Output RAM and event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (sif.dst_we === 1'b1) begin
      wr_count++;
      dst_mem[sif.dst_addr] = sif.dst_data;
      seen[sif.dst_addr]++;
    end
    if (sif.done === 1'b1) done_count++;
    if (sif.busy === 1'b1) busy_cycles++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] interp_part(input logic [17:0] lo, input logic [17:0] hi,
                                              input longint frac);
    longint l, h, r;
    l = longint'($signed(lo));
    h = longint'($signed(hi));
    r = l + (((h - l) * frac) >>> 14);
    return r[17:0];
  endfunction

  // Bin k of the resampled Hermitian spectrum, straight from position = k * ratio / 2^14.
  function automatic logic [DATA_W-1:0] model_bin(input int k, input logic [15:0] ratio);
    longint pos, idx, frac;
    logic [DATA_W-1:0] lo, hi;
    logic [17:0] im;
    if (k == HALF) return '0;
    if (k > HALF) begin
      lo = model_bin(N_BINS - k, ratio);
      im = lo[17:0];
      im = (im == 18'h20000) ? 18'h1FFFF : -im;
      return {lo[35:18], im};
    end
    pos  = longint'(k) * longint'(ratio);
    idx  = pos / 16384;
    frac = pos % 16384;
    if (idx >= HALF - 1) return '0;
    lo = src_mem[int'(idx)];
    hi = src_mem[int'(idx) + 1];
    return {interp_part(lo[35:18], hi[35:18], frac), interp_part(lo[17:0], hi[17:0], frac)};
  endfunction

  function automatic int exp_busy(input logic [15:0] ratio);
    int n;
    longint idx;
    n = 5 + 1;
    for (int k = 1; k < HALF; k++) begin
      idx = (longint'(k) * longint'(ratio)) / 16384;
      n += (idx < HALF - 1) ? 6 : 3;
    end
    return n;
  endfunction

  task automatic fill_random();
    for (int n = 0; n < N_BINS; n++)
      src_mem[n] = (n < HALF) ? {18'($urandom), 18'($urandom)} : '0;
  endtask

  task automatic fill_ramp();
    for (int n = 0; n < N_BINS; n++)
      src_mem[n] = (n < HALF) ? {18'(n), 18'(-n)} : '0;
  endtask

  task automatic run_check(input string name, input logic [15:0] ratio, input bit poke);
    int n, bad;
    wr_count = 0; done_count = 0; busy_cycles = 0;
    for (int a = 0; a < N_BINS; a++) begin
      seen[a] = 0;
      dst_mem[a] = 'x;
    end
    @(negedge clk);
    sif.start = 1'b1;
    sif.inv_ratio = ratio;
    @(negedge clk);
    sif.start = 1'b0;
    sif.inv_ratio = 16'($urandom);
    check({name, " busy_rise"}, 64'(sif.busy), 64'd1);
    n = 0;
    while (done_count == 0 && n < 4000) begin
      @(negedge clk);
      n++;
      if (poke && n == 40) begin
        sif.start = 1'b1;
        sif.inv_ratio = 16'($urandom);
      end
      if (poke && n == 41) sif.start = 1'b0;
    end
    check({name, " done_seen"}, 64'(n < 4000), 64'd1);
    repeat (4) @(negedge clk);
    check({name, " done_count"}, 64'(done_count), 64'd1);
    check({name, " write_count"}, 64'(wr_count), 64'(N_BINS));
    check({name, " busy_cycles"}, 64'(busy_cycles), 64'(exp_busy(ratio)));
    check({name, " busy_low"}, 64'(sif.busy), 64'd0);
    bad = 0;
    for (int a = 0; a < N_BINS; a++) if (seen[a] != 1) bad++;
    check({name, " addr_once"}, 64'(bad), 64'd0);
    for (int k = 0; k < N_BINS; k++)
      check($sformatf("%s bin%0d", name, k), 64'(dst_mem[k]), 64'(model_bin(k, ratio)));
  endtask

  initial begin
    reset = 1'b1;
    sif.start = 1'b0;
    sif.inv_ratio = '0;
    for (int n = 0; n < N_BINS; n++) src_mem[n] = '0;
    #12;
    check("reset busy", 64'(sif.busy), 64'd0);
    check("reset done", 64'(sif.done), 64'd0);
    check("reset dst_we", 64'(sif.dst_we), 64'd0);
    check("reset src_addr", 64'(sif.src_addr), 64'd0);
    check("reset dst_addr", 64'(sif.dst_addr), 64'd0);
    check("reset dst_data", 64'(sif.dst_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    fill_ramp();
    run_check("identity", 16'h4000, 1'b0);
    check("identity bin3", 64'(dst_mem[3]), 64'({18'd3, 18'h3FFFD}));
    check("identity bin255", 64'(dst_mem[255]), 64'd0);
    check("identity bin257", 64'(dst_mem[257]), 64'd0);
    check("identity bin509", 64'(dst_mem[509]), 64'({18'd3, 18'd3}));

    fill_random();
    run_check("octave_up", 16'h2000, 1'b0);
    fill_random();
    run_check("octave_down", 16'h8000, 1'b0);

    fill_random();
    src_mem[3] = {18'd0, 18'h20000};
    run_check("saturation", 16'h4000, 1'b0);
    check("saturation bin3", 64'(dst_mem[3]), 64'({18'd0, 18'h20000}));
    check("saturation bin509", 64'(dst_mem[509]), 64'({18'd0, 18'h1FFFF}));

    fill_random();
    run_check("zero_ratio", 16'h0000, 1'b0);

    fill_random();
    run_check("restart_ignored", 16'h3000 + 16'($urandom_range(0, 16'h1FFF)), 1'b1);

    @(negedge clk);
    sif.start = 1'b1;
    sif.inv_ratio = 16'h4000;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (100) @(negedge clk);
    done_count = 0;
    #2 reset = 1'b1;
    #1;
    check("midreset busy", 64'(sif.busy), 64'd0);
    check("midreset dst_we", 64'(sif.dst_we), 64'd0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midreset no_done", 64'(done_count), 64'd0);

    fill_random();
    run_check("after_reset", 16'($urandom_range(0, 16'hFFFF)), 1'b0);
    fill_random();
    run_check("random_ratio", 16'($urandom_range(16'h1000, 16'h7FFF)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
